// File: rtl/stage_de_if.sv
// Fetch-to-decode bus: global controls and the fetch slot flow from the
// master (fetch side) into decode; the decoded slot plus the jump and
// hazard feedback to fetch flow back out of decode (slave).
interface stage_de_if #(
   parameter int INST_W      = 16,
   parameter int INST_ADDR_W = 12,
   parameter int DATA_W      = 16
);
   logic                   en;
   logic                   stall;
   logic                   flush;
   logic [INST_ADDR_W-1:0] in_pc;
   logic [INST_W-1:0]      in_inst;
   logic                   in_flush;
   logic                   in_flush_jump;
   logic                   jump;
   logic [INST_ADDR_W-1:0] jump_addr;
   logic                   hazard_stall;
   logic                   out_valid;
   logic [INST_ADDR_W-1:0] out_pc;
   logic [3:0]             out_op;
   logic [3:0]             out_rd;
   logic [3:0]             out_rs1;
   logic [3:0]             out_rs2;
   logic [DATA_W-1:0]      out_imm;
   logic                   out_we;
   logic                   out_mem_rd;
   logic                   out_mem_wr;
   logic                   out_halt;
   logic                   out_illegal;

   modport master (
      output en, stall, flush, in_pc, in_inst, in_flush, in_flush_jump,
      input  jump, jump_addr, hazard_stall,
      input  out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2, out_imm,
      input  out_we, out_mem_rd, out_mem_wr, out_halt, out_illegal
   );

   modport slave (
      input  en, stall, flush, in_pc, in_inst, in_flush, in_flush_jump,
      output jump, jump_addr, hazard_stall,
      output out_valid, out_pc, out_op, out_rd, out_rs1, out_rs2, out_imm,
      output out_we, out_mem_rd, out_mem_wr, out_halt, out_illegal
   );
endinterface

// File: rtl/stage_de.sv
// Decode stage. Registers the fetch slot, cracks it into fields, immediate
// and control flags, squashes flushed/jump-shadow slots, resolves JMP back
// to fetch combinationally and holds fetch for one cycle on load-use.
// Handshake: a slot is accepted on every rising edge where en=1, stall=0
// and hazard_stall=0; out_valid marks a real instruction in the output
// register, and fetch must re-present the same slot while hazard_stall=1.
module stage_de #(
   parameter int INST_W      = 16,
   parameter int INST_ADDR_W = 12,
   parameter int DATA_W      = 16
) (
   input logic        clk,
   input logic        rst_n,
   stage_de_if.slave  bus
);
   typedef struct packed {
      logic                   valid;
      logic [INST_ADDR_W-1:0] pc;
      logic [3:0]             op;
      logic [3:0]             rd;
      logic [3:0]             rs1;
      logic [3:0]             rs2;
      logic [DATA_W-1:0]      imm;
      logic                   we;
      logic                   mem_rd;
      logic                   mem_wr;
      logic                   halt;
      logic                   illegal;
   } dec_t;

   localparam logic [3:0] OP_ADDI = 4'h8;
   localparam logic [3:0] OP_LI   = 4'h9;
   localparam logic [3:0] OP_LD   = 4'hA;
   localparam logic [3:0] OP_ST   = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_HALT = 4'hD;

   logic [INST_W-1:0] inst;
   logic [3:0]        op;
   logic              in_ok;
   logic              uses_rs1;
   logic              uses_rs2;
   logic              load_use;
   logic              hazard;
   dec_t              dec;
   dec_t              q;

   assign inst  = bus.in_inst;
   assign op    = inst[15:12];
   assign in_ok = !bus.in_flush && !bus.in_flush_jump;

   // Crack the presented instruction into fields, immediate and flags.
   always_comb begin
      dec      = '0;
      uses_rs1 = 1'b0;
      uses_rs2 = 1'b0;
      dec.valid = in_ok;
      dec.pc    = bus.in_pc;
      dec.op    = op;
      dec.rd    = inst[11:8];
      dec.rs1   = inst[7:4];
      dec.rs2   = inst[3:0];
      case (op)
         4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
            dec.we   = 1'b1;
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
         end
         OP_ADDI: begin
            dec.we   = 1'b1;
            dec.imm  = {{(DATA_W-4){inst[3]}}, inst[3:0]};
            uses_rs1 = 1'b1;
         end
         OP_LI: begin
            dec.we  = 1'b1;
            dec.imm = {{(DATA_W-8){inst[7]}}, inst[7:0]};
         end
         OP_LD: begin
            dec.we     = 1'b1;
            dec.mem_rd = 1'b1;
            dec.imm    = {{(DATA_W-4){inst[3]}}, inst[3:0]};
            uses_rs1   = 1'b1;
         end
         OP_ST: begin
            // Store data register lives in the rd slot of the encoding.
            dec.rs2    = inst[11:8];
            dec.rd     = 4'h0;
            dec.mem_wr = 1'b1;
            dec.imm    = {{(DATA_W-4){inst[3]}}, inst[3:0]};
            uses_rs1   = 1'b1;
            uses_rs2   = 1'b1;
         end
         OP_HALT: dec.halt = 1'b1;
         4'hE, 4'hF: dec.illegal = 1'b1;
         default: ;
      endcase
      if (dec.rd == 4'h0) dec.we = 1'b0;
      if (!in_ok) begin
         dec.we      = 1'b0;
         dec.mem_rd  = 1'b0;
         dec.mem_wr  = 1'b0;
         dec.halt    = 1'b0;
         dec.illegal = 1'b0;
      end
   end

   // Load in the output slot whose destination feeds the presented slot.
   always_comb begin
      load_use = q.valid && q.mem_rd && (q.rd != 4'h0) &&
                 ((uses_rs1 && (dec.rs1 == q.rd)) ||
                  (uses_rs2 && (dec.rs2 == q.rd)));
      hazard   = bus.en && !bus.stall && !bus.flush && in_ok && load_use;
   end

   // Output slot register: hold, bubble on flush/hazard, else load decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (bus.en && !bus.stall) begin
         if (bus.flush || hazard) q <= '0;
         else                     q <= dec;
      end
   end

   assign bus.hazard_stall = hazard;
   // rst_n gates jump so fetch never sees a redirect while decode is in reset.
   assign bus.jump         = rst_n && bus.en && !bus.stall && !bus.flush &&
                             !hazard && in_ok && (op == OP_JMP);
   assign bus.jump_addr    = inst[11:0];

   assign bus.out_valid   = q.valid;
   assign bus.out_pc      = q.pc;
   assign bus.out_op      = q.op;
   assign bus.out_rd      = q.rd;
   assign bus.out_rs1     = q.rs1;
   assign bus.out_rs2     = q.rs2;
   assign bus.out_imm     = q.imm;
   assign bus.out_we      = q.we;
   assign bus.out_mem_rd  = q.mem_rd;
   assign bus.out_mem_wr  = q.mem_wr;
   assign bus.out_halt    = q.halt;
   assign bus.out_illegal = q.illegal;
endmodule

// File: tb/tb_stage_de.sv
// Bench for the decode stage: directed scenarios followed by a random
// instruction stream, all compared against a behavioural slot model.
module tb_stage_de;
   logic clk;
   logic rst_n;

   stage_de_if #(.INST_W(16), .INST_ADDR_W(12), .DATA_W(16)) bus ();

   stage_de #(.INST_W(16), .INST_ADDR_W(12), .DATA_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model of one decoded slot.
   typedef struct {
      bit valid;
      int pc, op, rd, rs1, rs2, imm;
      bit we, mem_rd, mem_wr, halt, illegal;
      bit u1, u2;
   } slot_t;

   slot_t m;
   bit    obs_haz, obs_jmp;
   int    obs_jaddr;
   bit    exp_haz_last, exp_jmp_last;

   function automatic int sext(input int v, input int bits);
      if (v >= (1 << (bits - 1))) return (v - (1 << bits)) & 32'hFFFF;
      return v;
   endfunction

   function automatic slot_t bubble();
      slot_t s;
      s = '{default: 0};
      return s;
   endfunction

   function automatic slot_t model_decode(input int pc, input int inst, input bit ok);
      slot_t s;
      s = '{default: 0};
      s.valid = ok;
      s.pc  = pc & 'hFFF;
      s.op  = (inst >> 12) & 15;
      s.rd  = (inst >> 8) & 15;
      s.rs1 = (inst >> 4) & 15;
      s.rs2 = inst & 15;
      if (s.op >= 1 && s.op <= 7) begin
         s.we = 1; s.u1 = 1; s.u2 = 1;
      end else if (s.op == 8) begin
         s.we = 1; s.u1 = 1; s.imm = sext(inst & 15, 4);
      end else if (s.op == 9) begin
         s.we = 1; s.imm = sext(inst & 255, 8);
      end else if (s.op == 10) begin
         s.we = 1; s.mem_rd = 1; s.u1 = 1; s.imm = sext(inst & 15, 4);
      end else if (s.op == 11) begin
         s.rs2 = s.rd; s.rd = 0; s.mem_wr = 1; s.u1 = 1; s.u2 = 1;
         s.imm = sext(inst & 15, 4);
      end else if (s.op == 13) begin
         s.halt = 1;
      end else if (s.op >= 14) begin
         s.illegal = 1;
      end
      if (s.rd == 0) s.we = 0;
      if (!ok) begin
         s.we = 0; s.mem_rd = 0; s.mem_wr = 0; s.halt = 0; s.illegal = 0;
      end
      return s;
   endfunction

   task automatic check_outputs();
      check("out_valid",   bus.out_valid,   m.valid);
      check("out_we",      bus.out_we,      m.we);
      check("out_mem_rd",  bus.out_mem_rd,  m.mem_rd);
      check("out_mem_wr",  bus.out_mem_wr,  m.mem_wr);
      check("out_halt",    bus.out_halt,    m.halt);
      check("out_illegal", bus.out_illegal, m.illegal);
      if (m.valid) begin
         check("out_pc",  bus.out_pc,  m.pc);
         check("out_op",  bus.out_op,  m.op);
         check("out_rd",  bus.out_rd,  m.rd);
         check("out_rs1", bus.out_rs1, m.rs1);
         check("out_rs2", bus.out_rs2, m.rs2);
         check("out_imm", bus.out_imm, m.imm);
      end
   endtask

   // Driver: present one slot after a falling edge, check fetch feedback,
   // clock it, then check the registered slot at the next falling edge.
   task automatic step(input bit e, input bit st, input bit fl, input int pc,
                       input int inst, input bit ifl, input bit ifj);
      slot_t d;
      bit    ok, haz, jmp;
      bus.en = e; bus.stall = st; bus.flush = fl;
      bus.in_pc = pc[11:0]; bus.in_inst = inst[15:0];
      bus.in_flush = ifl; bus.in_flush_jump = ifj;
      #1;
      ok  = !ifl && !ifj;
      d   = model_decode(pc, inst, ok);
      haz = rst_n && e && !st && !fl && ok && m.valid && m.mem_rd && m.rd != 0 &&
            ((d.u1 && d.rs1 == m.rd) || (d.u2 && d.rs2 == m.rd));
      jmp = rst_n && e && !st && !fl && !haz && ok && d.op == 12;
      obs_haz = bus.hazard_stall; obs_jmp = bus.jump; obs_jaddr = int'(bus.jump_addr);
      check("hazard_stall", bus.hazard_stall, haz);
      check("jump", bus.jump, jmp);
      if (jmp) check("jump_addr", bus.jump_addr, inst & 'hFFF);
      exp_haz_last = haz; exp_jmp_last = jmp;
      @(posedge clk);
      if (e && !st) begin
         if (fl || haz) m = bubble();
         else           m = d;
      end
      @(negedge clk);
      check_outputs();
   endtask

   // Stimulus.
   initial begin
      int pc, inst, op;
      bit e, st, fl, ifl, ifj, hold;
      m = bubble();
      rst_n = 1'b0;
      bus.en = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
      bus.in_pc = '0; bus.in_inst = '0; bus.in_flush = 1'b0; bus.in_flush_jump = 1'b0;
      repeat (2) @(negedge clk);
      check_outputs();
      check("rst_jump", bus.jump, 0);
      check("rst_hazard", bus.hazard_stall, 0);
      rst_n = 1'b1;

      // ADD r1,r2,r3
      step(1, 0, 0, 'h010, 'h1123, 0, 0);
      check("t2_op", bus.out_op, 1);
      check("t2_rd", bus.out_rd, 1);
      check("t2_rs1", bus.out_rs1, 2);
      check("t2_rs2", bus.out_rs2, 3);
      check("t2_we", bus.out_we, 1);

      // Load-use: LD r4,[r5-1] then ADD r6,r4,r0
      step(1, 0, 0, 'h011, 'hA45F, 0, 0);
      check("t3_imm", bus.out_imm, 'hFFFF);
      step(1, 0, 0, 'h012, 'h1640, 0, 0);
      check("t3_haz", obs_haz, 1);
      check("t3_bubble", bus.out_valid, 0);
      step(1, 0, 0, 'h012, 'h1640, 0, 0);
      check("t3_haz_gone", obs_haz, 0);
      check("t3_add_issued", bus.out_op, 1);
      // Load to r0 never stalls.
      step(1, 0, 0, 'h013, 'hA05F, 0, 0);
      step(1, 0, 0, 'h014, 'h1600, 0, 0);
      check("t3_r0_haz", obs_haz, 0);

      // JMP 0x123 and its squashed shadow slot.
      step(1, 0, 0, 'h015, 'hC123, 0, 0);
      check("t4_jump", obs_jmp, 1);
      check("t4_jaddr", obs_jaddr, 'h123);
      check("t4_jmp_we", bus.out_we, 0);
      step(1, 0, 0, 'h016, 'h1123, 0, 1);
      check("t4_shadow", bus.out_valid, 0);

      // Stall with flush held is frozen; flush after release bubbles.
      step(1, 0, 0, 'h123, 'h1234, 0, 0);
      for (int i = 0; i < 3; i++) step(1, 1, 1, 'h124 + i, 'h2345, 0, 0);
      check("t5_frozen", bus.out_op, 1);
      step(1, 0, 1, 'h127, 'h2345, 0, 0);
      check("t5_flush", bus.out_valid, 0);

      // Illegal, HALT, flushed NOP.
      step(1, 0, 0, 'h130, 'hE000, 0, 0);
      check("t6_illegal", bus.out_illegal, 1);
      check("t6_ill_valid", bus.out_valid, 1);
      step(1, 0, 0, 'h131, 'hD000, 0, 0);
      check("t6_halt", bus.out_halt, 1);
      step(1, 0, 0, 'h132, 'h0000, 1, 0);
      check("t6_nop_flushed", bus.out_valid, 0);

      // Asynchronous reset mid-stream with a JMP presented.
      step(1, 0, 0, 'h140, 'hA11F, 0, 0);
      bus.in_inst = 16'hC456;
      #2 rst_n = 1'b0;
      #1;
      check("t1_valid", bus.out_valid, 0);
      check("t1_jump", bus.jump, 0);
      check("t1_hazard", bus.hazard_stall, 0);
      m = bubble();
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 0, 0, 'h141, 'h9512, 0, 0);
      check("t1_first_slot", bus.out_imm, 'h0012);

      // Random stream with a fetch emulation honouring hold and jump shadow.
      pc = 'h200; inst = 'h0000; ifl = 0; ifj = 0; hold = 0;
      exp_haz_last = 0; exp_jmp_last = 0;
      for (int n = 0; n < 3000; n++) begin
         if (exp_jmp_last) begin
            ifj = 1;
            pc  = (pc + 1) & 'hFFF;
            inst = $urandom_range(0, 'hFFFF);
            ifl = 0;
         end else if (!hold) begin
            pc  = (pc + 1) & 'hFFF;
            op  = ($urandom_range(0, 3) == 0) ? 10 : $urandom_range(0, 15);
            inst = (op << 12) | ($urandom_range(0, 3) << 8) |
                   ($urandom_range(0, 3) << 4) | $urandom_range(0, 3);
            ifl = ($urandom_range(0, 9) == 0);
            ifj = 0;
         end
         e  = ($urandom_range(0, 9) != 0);
         st = ($urandom_range(0, 6) == 0);
         fl = ($urandom_range(0, 9) == 0);
         step(e, st, fl, pc, inst, ifl, ifj);
         hold = exp_haz_last || !e || st;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
